// File: rtl/riscv_pkg.sv
// Shared funct3 codes, stage state encoding and a funct3 legality helper for the
// memory/writeback stage.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Doubleword and LWU encodings only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                    input logic xlen64);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || ((f3 == F3_SD) && xlen64);
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        F3_LD, F3_LWU:                       ok = xlen64;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: shifts the addressed lane down to bit 0 and applies
// sign/zero extension selected by funct3.
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           rdata,
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    result  = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(shifted[7:0]));
      F3_LH:   result = XLEN'($signed(shifted[15:0]));
      F3_LW:   result = XLEN'($signed(shifted[31:0]));
      F3_LD:   result = shifted;
      F3_LBU:  result = XLEN'(shifted[7:0]);
      F3_LHU:  result = XLEN'(shifted[15:0]);
      F3_LWU:  result = XLEN'(shifted[31:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_mem_writeback.sv
// Memory-access / writeback stage feeding the register file write port.
// Optional misaligned-access trap enabled by defining RISCV_MISALIGN_TRAP_EN.
module riscv_mem_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_rd_write,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [4:0]        rd_addr,
  output logic              rd_enable_write,
  output logic [XLEN-1:0]   rd_data,
  output logic              retire,
  output logic              misaligned_fault
);

  localparam int   NB     = XLEN / 8;
  localparam int   OW     = $clog2(NB);
  localparam logic XLEN64 = (XLEN == 64);

  state_t          state;
  logic [4:0]      pend_rd;
  logic            pend_wr;
  logic            pend_load;
  logic [2:0]      pend_f3;
  logic [OW-1:0]   pend_lane;

  logic            accept;
  logic            is_mem;
  logic            legal;
  logic            trap;
  logic [OW-1:0]   addr_lo;
  logic [OW-1:0]   size_mask;
  logic [OW-1:0]   lane;
  logic [NB-1:0]   base_strb;
  logic [XLEN-1:0] load_result;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = in_is_load | in_is_store;
  assign legal    = f3_legal(in_is_store, in_funct3, XLEN64);
  assign addr_lo  = in_alu_result[OW-1:0];

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   size_mask = '0;
      2'b01:   size_mask = OW'(1);
      2'b10:   size_mask = OW'(3);
      default: size_mask = OW'(7);
    endcase
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   base_strb = NB'(1);
      2'b01:   base_strb = NB'(3);
      2'b10:   base_strb = NB'(15);
      default: base_strb = {NB{1'b1}};
    endcase
  end

  // Without the trap, low address bits below the access size are simply dropped.
  assign lane = addr_lo & ~size_mask;

`ifdef RISCV_MISALIGN_TRAP_EN
  assign trap = |(addr_lo & size_mask);
`else
  assign trap = 1'b0;
`endif

  riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rdata),
    .lane   (pend_lane),
    .funct3 (pend_f3),
    .result (load_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
      rd_addr         <= '0;
      rd_enable_write <= 1'b0;
      rd_data         <= '0;
      retire          <= 1'b0;
      pend_rd         <= '0;
      pend_wr         <= 1'b0;
      pend_load       <= 1'b0;
      pend_f3         <= '0;
      pend_lane       <= '0;
`ifdef RISCV_MISALIGN_TRAP_EN
      misaligned_fault <= 1'b0;
`endif
    end else begin
      rd_enable_write <= 1'b0;
      retire          <= 1'b0;
`ifdef RISCV_MISALIGN_TRAP_EN
      misaligned_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              rd_addr         <= in_rd_addr;
              rd_data         <= in_alu_result;
              rd_enable_write <= in_rd_write & (in_rd_addr != 5'd0);
              retire          <= 1'b1;
            end else if (!legal || trap) begin
              // Dropped memory op still retires so the pipeline keeps its count.
              retire <= 1'b1;
`ifdef RISCV_MISALIGN_TRAP_EN
              misaligned_fault <= legal & trap;
`endif
            end else begin
              state     <= MEM_WAIT;
              mem_req   <= 1'b1;
              mem_we    <= in_is_store;
              mem_addr  <= {in_alu_result[XLEN-1:OW], {OW{1'b0}}};
              mem_wdata <= in_store_data << {lane, 3'b000};
              mem_wstrb <= in_is_store ? (base_strb << lane) : '0;
              pend_rd   <= in_rd_addr;
              pend_wr   <= in_rd_write;
              pend_load <= in_is_load;
              pend_f3   <= in_funct3;
              pend_lane <= lane;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            retire  <= 1'b1;
            if (pend_load) begin
              rd_addr         <= pend_rd;
              rd_data         <= load_result;
              rd_enable_write <= pend_wr & (pend_rd != 5'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RISCV_MISALIGN_TRAP_EN
  assign misaligned_fault = 1'b0;
`endif

endmodule

// File: doc/riscv_mem_writeback.md
Name: riscv_mem_writeback

Overview:
- Memory-access/writeback stage directly upstream of riscv_register_file; drives its rd_addr / rd_enable_write / rd_data write port.
- Accepts one executed instruction per handshake: ALU result, load, or store.
- Issues loads/stores to data memory over a req/ack handshake, then aligns and extends load data.
- Produces exactly one registered register-file write per completing instruction that writes rd.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready.
- in_rd_addr  in  5  destination register.
- in_rd_write  in  1  instruction writes rd; ignored for stores.
- in_is_load  in  1  load instruction.
- in_is_store  in  1  store instruction; in_is_load & in_is_store never both set.
- in_funct3  in  3  RISC-V load/store width/sign code.
- in_alu_result  in  XLEN  result for ALU ops; effective address for memory ops.
- in_store_data  in  XLEN  rs2 value for stores.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = store.
- mem_addr  out  XLEN  address aligned down to XLEN/8 bytes.
- mem_wdata  out  XLEN  store data replicated or shifted into byte lanes.
- mem_wstrb  out  XLEN/8  byte-lane write strobes.
- mem_ack  in  1  request complete; mem_rdata valid this cycle for loads.
- mem_rdata  in  XLEN  full aligned read word.
- rd_addr  out  5  to register file.
- rd_enable_write  out  1  to register file; one-cycle pulse per write.
- rd_data  out  XLEN  to register file.
- retire  out  1  one-cycle pulse per completed instruction.
- misaligned_fault  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 and state IDLE, except in_ready = 1 after reset.
- States: IDLE and MEM_WAIT.
- IDLE: in_ready = 1.
  - ALU op accepted: next cycle rd_enable_write = in_rd_write & (in_rd_addr != 0), rd_data = in_alu_result, retire = 1. Sustains 1 instruction/cycle.
  - Load or store accepted: next cycle state = MEM_WAIT and mem_req = 1, with mem_we, mem_addr, mem_wdata and mem_wstrb registered at acceptance.
- MEM_WAIT: in_ready = 0.
  - All mem_* outputs are stable until the cycle mem_ack = 1.
  - On mem_ack: mem_req drops next cycle and state returns to IDLE.
  - Load: next cycle rd_enable_write pulses (suppressed if rd = x0), rd_data = extended data, retire = 1. Total load latency = memory wait + 2 cycles.
  - Store: retire pulses next cycle, no register write.
- Load extension uses lane = address low bits:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW sign-extends on XLEN=64 and passes through on 32.
  - LWU and LD are valid only on XLEN=64.
- Store lanes: SB sets 1 strobe, SH sets 2, SW sets 4, SD sets 8; wdata is shifted to the lane.
- Unsupported funct3 for XLEN (e.g. 011 on XLEN=32, or any 1xx store): no memory request, no write, retire still pulses.
- mem_ack while in IDLE is ignored.
- Reset in MEM_WAIT: mem_req = 0 and state = IDLE next cycle; the pending write is dropped and a late mem_ack is ignored.

Optional Feature:
- Macro: RISCV_MISALIGN_TRAP_EN.
- Defined: a memory op whose address is not naturally aligned to its access size issues no request and writes nothing. Next cycle misaligned_fault = 1 and retire = 1, and the stage stays in IDLE.
- Undefined: misaligned_fault is tied 0; the address is truncated to access-size alignment and the access is performed normally.

Decomposition:
- riscv_pkg holds:
  - funct3 constants: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110; SB/SH/SW/SD = 000/001/010/011.
  - State enum typedef {IDLE, MEM_WAIT}.
- Sub-module riscv_load_align (combinational): takes rdata, address low bits and funct3; returns the extended XLEN result.

Test Plan:
- ALU stream: 3 back-to-back ops writing x1=0x11, x2=0x22, x0=0x33 -> rd_enable_write on cycles 1 and 2 only; 3 retire pulses; in_ready held 1.
- LB at addr 0x103, mem_rdata=0x80FF_FF7F with 2 wait cycles -> mem_addr=0x100, rd_data=0xFFFF_FF80 written 1 cycle after ack; in_ready=0 during the wait.
- LHU at 0x102, mem_rdata=0xBEEF_1234 -> rd_data=0x0000_BEEF.
- SB x=0x0000_00AB at 0x101 -> mem_we=1, mem_wstrb=0b0010, mem_wdata[15:8]=0xAB, no rd write, retire after ack.
- Reset asserted in MEM_WAIT, then mem_ack 2 cycles later -> mem_req=0 after reset, no write, no retire.
- With RISCV_MISALIGN_TRAP_EN: LW at 0x102 -> no mem_req, misaligned_fault and retire pulse; without the macro: mem_addr=0x100 and the load completes.
